// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DAT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DAT_W-1:0]  wdata;
        logic [LANES-1:0]  be;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array with byte-write mask and registered read data.
// Contents are intentionally not reset so they survive rst_n.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [LANES-1:0] be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [DAT_W-1:0] wdata_i,
    output logic [DAT_W-1:0] rdata_o
);

    logic [DAT_W-1:0] mem_q [DEPTH_WORDS];
    logic [DAT_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < int'(LANES); b++) begin
                    if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding request, programmable wait
// states, byte-enabled stores, whole-word loads and address checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DAT_WIDTH   = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DAT_WIDTH-1:0]  req_wdata_i,
    input  logic [LANES-1:0]      req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DAT_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rd_sel_q, rd_sel_d;

    // In IDLE the live request feeds the commit (zero-wait case); otherwise the captured one.
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DAT_W-1:0]      cur_wdata;
    logic [LANES-1:0]      cur_be;
    logic                  cur_err;
    logic                  commit;
    logic [DAT_W-1:0]      arr_rdata;

    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we_i    : req_q.we;
        cur_addr  = (state_q == IDLE) ? req_addr_i  : ADDR_WIDTH'(req_q.addr);
        cur_wdata = (state_q == IDLE) ? DAT_W'(req_wdata_i) : req_q.wdata;
        cur_be    = (state_q == IDLE) ? req_be_i    : req_q.be;
        cur_err   = (|cur_addr[1:0]) || (|(cur_addr >> (IDX_W + 2)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rsp_err_d = rsp_err_q;
        rd_sel_d  = rd_sel_q;
        commit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d.we    = req_we_i;
                    req_d.addr  = ADDR_W'(req_addr_i);
                    req_d.wdata = DAT_W'(req_wdata_i);
                    req_d.be    = req_be_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d   = IDLE;
                    rsp_err_d = 1'b0;
                    rd_sel_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_err_d = cur_err;
            rd_sel_d  = !cur_we && !cur_err;
        end

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (commit && !cur_err),
        .we_i    (cur_we),
        .be_i    (cur_be),
        .idx_i   (cur_addr[2 +: IDX_W]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_sel_q ? DAT_WIDTH'(arr_rdata) : '0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving load/store requests issued by the pipeline's Memory stage over a valid/ready request channel and a valid/ready response channel. It holds one outstanding request and inserts a programmable number of wait states. It performs byte-enabled word writes, whole-word reads and address checking. It sits between the CPU top and its word-addressed data storage, and replaces the zero-latency data memory so the pipeline can be exercised against realistic memory timing.

## Interface
- ADDR_WIDTH, 32, request address width
- DAT_WIDTH, 32, data width; fixed at 32 so that req_be is 4 bits
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two
- WAIT_CYCLES, 2, wait states inserted between acceptance and response; legal range 0..15
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assertion, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DAT_WIDTH  store data
- req_be  input  4  store byte enables; bit i enables bits [8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  DAT_WIDTH  load data; 0 for stores and for errors
- rsp_err  output  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture we/addr/wdata/be.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
  - The wait counter loads WAIT_CYCLES-1.
- WAIT:
  - req_ready = 0.
  - The counter decrements each cycle.
  - At 0, transition to RESP.
- Commit:
  - The array access happens on the clock edge that enters RESP.
  - A store writes only the enabled bytes.
  - A load samples the full word.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready = 1.
  - On the handshake, return to IDLE.
- Error check:
  - Condition: addr[1:0] != 0, or word index addr >> 2 >= DEPTH_WORDS.
  - Result: no array access; rsp_err = 1; rsp_rdata = 0.
- A store with be = 4'b0000 is legal. It leaves the array unchanged and gives rsp_err = 0.
- Word index = addr[2 +: $clog2(DEPTH_WORDS)]. Address bits above the range are checked as described under Error check.
- The storage array is not reset. Its contents survive rst_n.

## Timing
- Reset values: req_ready = 1 (IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, counter = 0.
- Latency from the acceptance edge to rsp_valid high is WAIT_CYCLES+1 cycles (1 cycle when WAIT_CYCLES = 0).
- rsp_valid is registered. req_ready is decoded from the state register only and has no combinational path from any input.
- There is no same-cycle turnaround. After the response handshake, req_ready rises in the following cycle. Minimum request spacing is WAIT_CYCLES+2 cycles.
- Back-pressure: if rsp_ready stays low, RESP holds indefinitely and all response outputs stay constant.
- Read-after-write: a load accepted after a store's response handshake returns the stored value.
- rst_n asserted in WAIT: the pending request is dropped and no write occurs.
- rst_n asserted in RESP: an already-committed store remains in the array; the response is discarded.
- A request presented while not in IDLE is ignored. It must be held by the requester until req_ready.

## Structure
- Package dmem_pkg holds:
  - the state enum typedef (IDLE/WAIT/RESP)
  - the captured-request struct typedef (we, addr, wdata, be)
  - the byte-lane count constant (4)
- Sub-module dmem_array:
  - Synchronous single-port word array with a 4-bit byte-write mask.
  - Ports: clk, en, we, be, idx, wdata, rdata. rdata is registered.
  - The responder drives en only on the commit edge.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.

## Test plan
- Reset check: hold rst_n = 0, then release -> req_ready = 1, rsp_valid = 0, rsp_err = 0.
- Store then load, WAIT_CYCLES = 2:
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF -> rsp_valid high 3 cycles after acceptance, rsp_err = 0.
  - Then load 0x10 -> rsp_rdata = 0xDEADBEEF.
- Partial store: store 0x11223344 with be 4'b0101 onto a word already holding 0xDEADBEEF -> a following load returns 0xDE22BE44.
- Error accesses:
  - Load 0x13 -> rsp_err = 1, rsp_rdata = 0.
  - Store to 4*DEPTH_WORDS -> rsp_err = 1, and the word at index 0 is unchanged.
- Back-pressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready = 0. Release -> req_ready = 1 on the next cycle.
- Reset in WAIT: issue a store of 0xCAFEF00D to 0x20, assert rst_n during WAIT, then load 0x20 -> the old value is returned and rsp_valid stayed 0 throughout reset.
